imem_boot_ctrl: RTL and testbench

Boot-load controller for the instruction memory. Receives a length-prefixed, checksummed byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words, and drives the instruction memory write port. The processor is held in reset until a complete, checksum-valid image is written; after that, the processor is released.

---
 rtl/imem_boot_ctrl_if.sv | 28 ++
 rtl/imem_boot_ctrl.sv | 133 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_ctrl_if.sv
// Signal bundle between the boot-load controller (master) and its environment:
// byte-stream input, instruction-memory write port and processor control outputs.
interface imem_boot_ctrl_if;
    // Byte handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
    // rx_data must hold while rx_valid is high and rx_ready is low.
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  state;

    modport master (
        input  start, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, cpu_reset, busy, done, err, state
    );

    modport slave (
        output start, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, cpu_reset, busy, done, err, state
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot-load controller: parses a length-prefixed, XOR-checksummed byte stream,
// writes little-endian words to instruction memory and releases the CPU on success.
module imem_boot_ctrl #(
    parameter int DEPTH = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    imem_boot_ctrl_if.master bus
);
    localparam int WI_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [WI_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rx_ready_q, cpu_reset_q, busy_q, done_q, err_q;
    logic              accept;
    logic [15:0]       n_hdr;

    assign accept = bus.rx_valid && rx_ready_q;
    assign n_hdr  = {bus.rx_data, n_q[7:0]};

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (bus.start) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (accept) begin
                    n_d     = LEN_W'(bus.rx_data);
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    n_d        = LEN_W'(n_hdr);
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                    word_d     = '0;
                    if (32'(n_hdr) > 32'(DEPTH)) state_d = S_ERROR;
                    else if (n_hdr == 16'd0)     state_d = S_CSUM;
                    else                         state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[8*byte_idx_q +: 8] = bus.rx_data;
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Last lane of a word: present the assembled word on the next cycle.
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        waddr_d    = {{(30-WI_W){1'b0}}, word_idx_q, 2'b00};
                        wdata_d    = word_d;
                        word_idx_d = word_idx_q + 1'b1;
                        if ((32'(word_idx_q) + 32'd1) == 32'(n_q)) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) state_d = (bus.rx_data == csum_q) ? S_RUN : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rx_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            // Status flags are decoded from the next state so they line up with state_q.
            rx_ready_q  <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                           (state_d == S_DATA) || (state_d == S_CSUM);
            busy_q      <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                           (state_d == S_DATA) || (state_d == S_CSUM);
            cpu_reset_q <= (state_d != S_RUN);
            done_q      <= (state_d == S_RUN);
            err_q       <= (state_d == S_ERROR);
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: byte-stream driver, write scoreboard fed by an
// image-level reference model, directed and randomized load scenarios.
module tb_imem_boot_ctrl;
  localparam int DEPTH = 64;

  logic clk;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic prev_we = 1'b0;

  imem_boot_ctrl_if bus();

  imem_boot_ctrl #(.DEPTH(DEPTH), .LEN_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write pulse must match the next expected {addr,data}
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_we: waddr=%h wdata=%h, no write expected", bus.waddr, bus.wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.waddr, bus.wdata} !== e) begin
          failures++;
          $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.waddr, bus.wdata, e[63:32], e[31:0]);
        end
      end
      checks++;
      if (prev_we === 1'b1) begin
        failures++;
        $display("FAIL we_spacing: we high on consecutive cycles, expected single-cycle pulses");
      end
    end
    prev_we = bus.we;
  end

  // reference model: XOR of all data bytes of an image
  function automatic logic [7:0] model_csum(input logic [31:0] words[$]);
    logic [7:0] x = 8'h00;
    foreach (words[i]) begin
      x = x ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    end
    return x;
  endfunction

  // driver tasks (all start and end #1 after a rising edge)
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    if (stall) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL rx_ready_timeout: rx_ready=%b, expected 1 within 20 cycles", bus.rx_ready);
    end else begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_start(input string name);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.rx_ready, bus.cpu_reset, bus.done, bus.err} !== 5'b11100) begin
      failures++;
      $display("FAIL %s_start: busy,rx_ready,cpu_reset,done,err=%b expected 11100", name,
               {bus.busy, bus.rx_ready, bus.cpu_reset, bus.done, bus.err});
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({bus.rx_ready, bus.we, bus.cpu_reset, bus.busy, bus.done, bus.err} !== 6'b001000 ||
        bus.waddr !== 32'h0 || bus.wdata !== 32'h0) begin
      failures++;
      $display("FAIL %s: rx_ready,we,cpu_reset,busy,done,err=%b waddr=%h wdata=%h expected 001000/0/0",
               name, {bus.rx_ready, bus.we, bus.cpu_reset, bus.busy, bus.done, bus.err},
               bus.waddr, bus.wdata);
    end
  endtask

  // One complete load. csum_ovr < 0 sends the correct checksum.
  task automatic run_image(input string name, input logic [31:0] words[$], input int n_hdr,
                           input int csum_ovr, input bit stall, input bit poke);
    logic [7:0] cs, cbyte;
    logic [31:0] w;
    bit ok;
    do_start(name);
    send_byte(8'(n_hdr), stall);
    send_byte(8'(n_hdr >> 8), stall);
    if (n_hdr > DEPTH) begin
      checks++;
      if ({bus.err, bus.rx_ready, bus.busy, bus.cpu_reset, bus.done} !== 5'b10010) begin
        failures++;
        $display("FAIL %s_oversize: err,rx_ready,busy,cpu_reset,done=%b expected 10010", name,
                 {bus.err, bus.rx_ready, bus.busy, bus.cpu_reset, bus.done});
      end
      return;
    end
    cs = model_csum(words);
    foreach (words[i]) exp_q.push_back({32'(i * 4), words[i]});
    foreach (words[i]) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], stall);
        if (poke && i == 0 && k == 0) begin
          bus.start = 1'b1;
          @(posedge clk); #1;
          bus.start = 1'b0;
          checks++;
          if ({bus.busy, bus.rx_ready} !== 2'b11) begin
            failures++;
            $display("FAIL %s_start_ignored: busy,rx_ready=%b expected 11", name, {bus.busy, bus.rx_ready});
          end
        end
      end
    end
    cbyte = (csum_ovr < 0) ? cs : 8'(csum_ovr);
    ok = (cbyte == cs);
    send_byte(cbyte, stall);
    checks++;
    if (bus.done !== ok) begin
      failures++;
      $display("FAIL %s_done: done=%b expected %b", name, bus.done, ok);
    end
    checks++;
    if (bus.err !== !ok) begin
      failures++;
      $display("FAIL %s_err: err=%b expected %b", name, bus.err, !ok);
    end
    checks++;
    if (bus.cpu_reset !== !ok) begin
      failures++;
      $display("FAIL %s_cpu_reset: cpu_reset=%b expected %b", name, bus.cpu_reset, !ok);
    end
    checks++;
    if ({bus.busy, bus.rx_ready} !== 2'b00) begin
      failures++;
      $display("FAIL %s_busy_end: busy,rx_ready=%b expected 00", name, {bus.busy, bus.rx_ready});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes_missing: %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // scenarios
  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    @(posedge clk);
    @(posedge clk); #1;
    bus.start = 1'b0;
    reset = 1'b0;
    check_idle_outputs("reset_values");
  endtask

  task automatic test_nominal;
    logic [31:0] w[$] = '{32'h00500013, 32'h000002B3};
    run_image("nominal", w, 2, 8'hF2, 1'b0, 1'b0);
  endtask

  task automatic test_bad_csum;
    logic [31:0] w[$] = '{32'h00500013, 32'h000002B3};
    run_image("bad_csum", w, 2, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_oversize;
    logic [31:0] w[$];
    run_image("oversize", w, DEPTH + 1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_length;
    logic [31:0] w[$];
    run_image("zero_len", w, 0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_stall_restart;
    logic [31:0] w[$] = '{32'h00500013, 32'h000002B3};
    logic [31:0] r[$];
    run_image("stall", w, 2, 8'hF2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) r.push_back($urandom);
    run_image("restart", r, 3, -1, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic [31:0] w[$];
    int n;
    for (int it = 0; it < 10; it++) begin
      w.delete();
      case ($urandom_range(0, 5))
        0: n = DEPTH;
        1: n = DEPTH + 1 + int'($urandom_range(0, 4000));
        default: n = int'($urandom_range(0, 9));
      endcase
      if (n <= DEPTH) for (int i = 0; i < n; i++) w.push_back($urandom);
      run_image("random", w, n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] w[$];
    do_start("mid_reset");
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h50;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outputs("mid_reset_values");
    for (int i = 0; i < 6; i++) begin
      bus.rx_data = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({bus.rx_ready, bus.busy, bus.cpu_reset} !== 3'b001) begin
        failures++;
        $display("FAIL mid_reset_no_accept: rx_ready,busy,cpu_reset=%b expected 001",
                 {bus.rx_ready, bus.busy, bus.cpu_reset});
      end
    end
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    run_image("after_reset", w, 4, -1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_bad_csum;
    test_oversize;
    test_zero_length;
    test_stall_restart;
    test_random;
    test_reset_mid_load;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
